// File: rtl/triangular_deskew_collector_if.sv
// Aligned-row output stream from the deskew collector toward the writeback unit.
// A head row transfers on every rising edge where out_valid && out_ready; while
// out_valid=1 and out_ready=0 the producer holds out_data/out_last stable.
interface triangular_deskew_collector_if #(
    parameter int DATAWIDTH = 32,
    parameter int N_SIZE    = 16
);
    logic [N_SIZE-1:0][DATAWIDTH-1:0] out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/triangular_deskew_collector.sv
// Undoes the systolic array output skew, tags tile-final rows and queues them in a FIFO.
// Optional saturating drop counter: define TDC_DROP_COUNT_EN.
module triangular_deskew_collector #(
    parameter int DATAWIDTH  = 32,
    parameter int N_SIZE     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS_W     = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_SIZE-1:0][DATAWIDTH-1:0] psum_in,
    input  logic                             psum_valid_in,
    input  logic [ROWS_W-1:0]                tile_rows,
    triangular_deskew_collector_if.master    out_if,
    output logic                             overflow,
`ifdef TDC_DROP_COUNT_EN
    output logic [15:0]                      drop_count,
`endif
    output logic                             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [N_SIZE-1:0][DATAWIDTH-1:0] row_t;

    row_t              aligned;
    logic [N_SIZE-2:0] vpipe;
    logic              wr_en;

    // Lane k lags lane 0 by k cycles, so it gets N_SIZE-1-k stages of delay.
    for (genvar k = 0; k < N_SIZE - 1; k++) begin : g_lane
        localparam int D = N_SIZE - 1 - k;
        logic [DATAWIDTH-1:0] sr [D];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < D; i++) sr[i] <= '0;
            end else begin
                sr[0] <= psum_in[k];
                for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
        end

        assign aligned[k] = sr[D-1];
    end
    assign aligned[N_SIZE-1] = psum_in[N_SIZE-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= psum_valid_in;
            for (int i = 1; i < N_SIZE - 1; i++) vpipe[i] <= vpipe[i-1];
        end
    end
    assign wr_en = vpipe[N_SIZE-2];

    row_t                  mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && out_if.out_ready;
    // A full FIFO still takes the row when the head leaves on the same edge.
    assign push  = wr_en && (!full || pop);
    assign drop  = wr_en && full && !pop;

    logic [ROWS_W-1:0] row_cnt;
    logic [ROWS_W-1:0] limit;
    logic [ROWS_W-1:0] cur_limit;
    logic              row_last;

    always_comb begin
        cur_limit = (row_cnt == '0) ? tile_rows : limit;
        row_last  = (cur_limit == '0) || (row_cnt == cur_limit - ROWS_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            last_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]]      <= aligned;
                last_mem[wr_ptr[AW-1:0]] <= row_last;
                wr_ptr                   <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Dropped rows leave the tile position untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt  <= '0;
            limit    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                if (row_cnt == '0) limit <= tile_rows;
                row_cnt <= row_last ? '0 : row_cnt + ROWS_W'(1);
            end
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef TDC_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

    assign out_if.out_valid = !empty;
    assign out_if.out_data  = mem[rd_ptr[AW-1:0]];
    assign out_if.out_last  = last_mem[rd_ptr[AW-1:0]];
    assign busy             = (|vpipe) || !empty;
endmodule
